seg_scan_ctrl: RTL and testbench

Sequencer and frame buffer for the 8-digit seven-segment decoder. It generates the 3-bit scan index from a clock prescaler. It accepts new display frames (data, enables, points, blink mask) over a valid/ready handshake and commits them only on frame boundaries, so no tearing is visible. Its outputs drive the decoder's data, les, point and scan inputs directly.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_tick_div.sv | 18 +
 rtl/seg_scan_ctrl.sv | 70 +++++++
 tb/tb_seg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, frame type and blink masking for the seven-segment scan controller
package seg_pkg;
    localparam int DIGITS   = 8;
    localparam int SCAN_W   = 3;
    localparam int NIBBLE_W = 4;

    typedef struct packed {
        logic [DIGITS*NIBBLE_W-1:0] data;
        logic [DIGITS-1:0]          les;
        logic [DIGITS-1:0]          point;
        logic [DIGITS-1:0]          blink;
    } seg_frame_t;

    function automatic logic [DIGITS-1:0] visible_les(input seg_frame_t f, input logic phase);
        return f.les & ~(f.blink & {DIGITS{phase}});
    endfunction
endpackage

// File: rtl/seg_tick_div.sv
// seg_tick_div: enable-gated divider, tick is high while en=1 and the count sits at DIV-1
module seg_tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(DIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan sequencer and tear-free frame buffer for the 8-digit decoder
// SEG_BLINK_EN adds per-digit blinking every BLINK_FRAMES frames
module seg_scan_ctrl import seg_pkg::*; #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DIGITS*NIBBLE_W-1:0] req_data,
    input  logic [DIGITS-1:0]          req_les,
    input  logic [DIGITS-1:0]          req_point,
    input  logic [DIGITS-1:0]          req_blink,
    output logic [DIGITS*NIBBLE_W-1:0] data,
    output logic [DIGITS-1:0]          les,
    output logic [DIGITS-1:0]          point,
    output logic [SCAN_W-1:0]          scan,
    output logic                       frame_tick
);
    logic             slot_tick, pend_full, commit, nxt_phase;
    logic [DIGITS-1:0] blink_in;
    seg_frame_t       pend, act, nxt;

    seg_tick_div #(.DIV(SCAN_DIV)) u_slot (.clk, .rst_n, .en, .tick(slot_tick));

    assign frame_tick = slot_tick && scan == SCAN_W'(DIGITS - 1);
    assign commit     = frame_tick && pend_full;
    assign nxt        = commit ? pend : act;
    assign req_ready  = ~pend_full;
    assign data       = act.data;
    assign point      = act.point;

`ifdef SEG_BLINK_EN
    logic blink_tick, blink_phase;
    seg_tick_div #(.DIV(BLINK_FRAMES)) u_blink (.clk, .rst_n, .en(frame_tick), .tick(blink_tick));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            blink_phase <= 1'b0;
        else
            blink_phase <= blink_phase ^ blink_tick;
    assign nxt_phase = blink_phase ^ blink_tick;
    assign blink_in  = req_blink;
`else
    logic unused_blink;
    assign unused_blink = ^{req_blink, 32'(BLINK_FRAMES)};
    assign nxt_phase    = 1'b0;
    assign blink_in     = '0;
`endif

    // les is computed from next-cycle frame and phase so it lines up with data on commit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            scan      <= '0;
            pend      <= '0;
            act       <= '0;
            pend_full <= 1'b0;
            les       <= '0;
        end else begin
            scan <= scan + SCAN_W'(slot_tick);
            if (req_valid && !pend_full) begin
                pend      <= '{data: req_data, les: req_les, point: req_point, blink: blink_in};
                pend_full <= 1'b1;
            end else if (commit)
                pend_full <= 1'b0;
            act <= nxt;
            les <= en ? visible_les(nxt, nxt_phase) : '0;
        end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized checks of seg_scan_ctrl against a cycle-count reference model
module tb_seg_scan_ctrl;
    import seg_pkg::*;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = SD * DIGITS;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic clk = 0, rst_n = 0, en = 0, req_valid = 0, req_ready, frame_tick;
    logic [31:0] req_data = 0, data;
    logic [7:0] req_les = 0, req_point = 0, req_blink = 0, les, point;
    logic [2:0] scan;
    int n_cmp = 0, n_bad = 0;

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_les(req_les), .req_point(req_point), .req_blink(req_blink),
        .data(data), .les(les), .point(point), .scan(scan), .frame_tick(frame_tick));

    always #5 clk = ~clk;

    // Reference: scan position is a function of the number of enabled cycles since reset
    seg_frame_t m_pend, m_act, m_nx;
    bit m_pf, m_ft, m_cm;
    int en_cnt, ft_cnt, m_ph;
    logic [7:0] m_les;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_act = '0; m_pf = 0; en_cnt = 0; ft_cnt = 0; m_les = 8'h00;
        end else begin
            m_ft = en && (en_cnt % FRAME == FRAME - 1);
            m_cm = m_ft && m_pf;
            m_nx = m_cm ? m_pend : m_act;
            ft_cnt += int'(m_ft);
            m_ph = BLINK_ON ? (ft_cnt / BF) % 2 : 0;
            m_les = en ? (m_nx.les & ~(m_nx.blink & {8{m_ph[0]}})) : 8'h00;
            if (req_valid && !m_pf) begin
                m_pend = '{req_data, req_les, req_point, BLINK_ON ? req_blink : 8'h00};
                m_pf = 1;
            end else if (m_cm)
                m_pf = 0;
            m_act = m_nx;
            if (en) en_cnt++;
        end
    end

    function automatic logic [2:0] exp_scan();
        return 3'((en_cnt / SD) % DIGITS);
    endfunction
    function automatic logic exp_ft();
        return en && (en_cnt % FRAME == FRAME - 1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] l, input logic [7:0] p, input logic [7:0] b);
        req_data = d; req_les = l; req_point = p; req_blink = b; req_valid = 1;
        cyc();
        req_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 1;
        cyc(); cyc();
        n_cmp += 5;
        if (scan !== 3'd0) begin n_bad++; $display("FAIL reset_scan: got %0d want 0", scan); end
        if (data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data); end
        if (les !== 8'h00) begin n_bad++; $display("FAIL reset_les: got %h want 00", les); end
        if (point !== 8'h00) begin n_bad++; $display("FAIL reset_point: got %h want 00", point); end
        if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_ft: got %b want 0", frame_tick); end
        rst_n = 1;
        cyc();
        n_cmp += 2;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        if (scan !== 3'd0) begin n_bad++; $display("FAIL release_scan: got %0d want 0", scan); end
    endtask

    task automatic test_scan();
        int ticks = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            n_cmp += 3;
            if (scan !== exp_scan()) begin n_bad++; $display("FAIL scan_step: got %0d want %0d", scan, exp_scan()); end
            if (frame_tick !== exp_ft()) begin n_bad++; $display("FAIL scan_ft: got %b want %b", frame_tick, exp_ft()); end
            if (les !== m_les) begin n_bad++; $display("FAIL scan_les: got %h want %h", les, m_les); end
            ticks += int'(frame_tick);
            cyc();
        end
        n_cmp++;
        if (ticks != 3) begin n_bad++; $display("FAIL scan_ft_count: got %0d want 3", ticks); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 200 && exp_scan() != 3'd3; i++) cyc();
        n_cmp++;
        if (exp_scan() != 3'd3) begin n_bad++; $display("FAIL load_wait: got scan %0d want 3", exp_scan()); end
        offer(32'h1234_5678, 8'hFF, 8'h01, 8'h00);
        for (int i = 0; i < FRAME + 8; i++) begin
            n_cmp += 4;
            if (data !== m_act.data) begin n_bad++; $display("FAIL load_data: got %h want %h", data, m_act.data); end
            if (les !== m_les) begin n_bad++; $display("FAIL load_les: got %h want %h", les, m_les); end
            if (point !== m_act.point) begin n_bad++; $display("FAIL load_point: got %h want %h", point, m_act.point); end
            if (req_ready !== !m_pf) begin n_bad++; $display("FAIL load_ready: got %b want %b", req_ready, !m_pf); end
            cyc();
        end
        n_cmp += 2;
        if (data !== 32'h1234_5678) begin n_bad++; $display("FAIL load_final_data: got %h want 12345678", data); end
        if (les !== 8'hFF) begin n_bad++; $display("FAIL load_final_les: got %h want ff", les); end
    endtask

    task automatic test_back_to_back();
        seg_frame_t q[4];
        int idx = 0;
        bit rdy;
        for (int k = 0; k < 4; k++) q[k] = '{$urandom, 8'($urandom), 8'($urandom), 8'($urandom)};
        req_data = q[0].data; req_les = q[0].les; req_point = q[0].point; req_blink = q[0].blink;
        req_valid = 1;
        for (int i = 0; i < 6 * FRAME && idx < 4; i++) begin
            rdy = req_ready;
            cyc();
            n_cmp += 4;
            if (data !== m_act.data) begin n_bad++; $display("FAIL b2b_data: got %h want %h", data, m_act.data); end
            if (les !== m_les) begin n_bad++; $display("FAIL b2b_les: got %h want %h", les, m_les); end
            if (point !== m_act.point) begin n_bad++; $display("FAIL b2b_point: got %h want %h", point, m_act.point); end
            if (req_ready !== !m_pf) begin n_bad++; $display("FAIL b2b_ready: got %b want %b", req_ready, !m_pf); end
            if (rdy) begin
                idx++;
                if (idx < 4) begin
                    req_data = q[idx].data; req_les = q[idx].les; req_point = q[idx].point; req_blink = q[idx].blink;
                end else req_valid = 0;
            end
        end
        req_valid = 0;
        n_cmp++;
        if (idx != 4) begin n_bad++; $display("FAIL b2b_timeout: accepted %0d want 4", idx); end
        for (int i = 0; i < 2 * FRAME; i++) cyc();
        n_cmp++;
        if (data !== q[3].data) begin n_bad++; $display("FAIL b2b_last: got %h want %h", data, q[3].data); end
    endtask

    task automatic test_en();
        for (int i = 0; i < 200 && exp_scan() != 3'd5; i++) cyc();
        cyc();
        en = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_cmp += 2;
            if (scan !== 3'd5) begin n_bad++; $display("FAIL en_hold_scan: got %0d want 5", scan); end
            if (les !== 8'h00) begin n_bad++; $display("FAIL en_blank_les: got %h want 00", les); end
        end
        en = 1;
        for (int i = 0; i < 20; i++) begin
            n_cmp += 3;
            if (scan !== exp_scan()) begin n_bad++; $display("FAIL en_resume_scan: got %0d want %0d", scan, exp_scan()); end
            if (les !== m_les) begin n_bad++; $display("FAIL en_resume_les: got %h want %h", les, m_les); end
            if (frame_tick !== exp_ft()) begin n_bad++; $display("FAIL en_resume_ft: got %b want %b", frame_tick, exp_ft()); end
            cyc();
        end
    endtask

    task automatic test_blink();
        int seen_fe = 0;
        for (int i = 0; i < 200 && m_pf; i++) cyc();
        offer($urandom, 8'hFF, 8'h00, 8'h01);
        for (int i = 0; i < 6 * FRAME; i++) begin
            n_cmp++;
            if (les !== m_les) begin n_bad++; $display("FAIL blink_les: got %h want %h", les, m_les); end
            seen_fe += int'(les == 8'hFE);
            cyc();
        end
        n_cmp++;
        if ((seen_fe > 0) != BLINK_ON) begin n_bad++; $display("FAIL blink_seen: got %0d cycles of fe, blink %b", seen_fe, BLINK_ON); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 200 && m_pf; i++) cyc();
        for (int i = 0; i < 200 && exp_scan() != 3'd1; i++) cyc();
        offer(32'hDEAD_BEEF, 8'h5A, 8'hA5, 8'h00);
        for (int i = 0; i < 200 && exp_scan() != 3'd6; i++) cyc();
        n_cmp += 2;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_pending: got ready %b want 0", req_ready); end
        if (scan !== 3'd6) begin n_bad++; $display("FAIL mid_scan: got %0d want 6", scan); end
        rst_n = 0;
        #1;
        n_cmp += 5;
        if (scan !== 3'd0) begin n_bad++; $display("FAIL mid_rst_scan: got %0d want 0", scan); end
        if (data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h want 0", data); end
        if (les !== 8'h00) begin n_bad++; $display("FAIL mid_rst_les: got %h want 00", les); end
        if (point !== 8'h00) begin n_bad++; $display("FAIL mid_rst_point: got %h want 00", point); end
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
        cyc();
        rst_n = 1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            n_cmp += 3;
            if (data !== 32'h0) begin n_bad++; $display("FAIL mid_stale_data: got %h want 0", data); end
            if (scan !== exp_scan()) begin n_bad++; $display("FAIL mid_post_scan: got %0d want %0d", scan, exp_scan()); end
            if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_post_ready: got %b want 1", req_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_en();
        test_blink();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
